// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 keyboard receiver.
// Covers frame FSM states, set-2 prefix bytes and controller response codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_REL    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam logic [7:0] BAT    = 8'hAA;
    localparam logic [7:0] ACK    = 8'hFA;
    localparam logic [7:0] ECHO   = 8'hEE;
    localparam logic [7:0] RESEND = 8'hFE;
    localparam logic [7:0] ERR0   = 8'h00;
    localparam logic [7:0] ERR1   = 8'hFF;

    // Controller responses are passed as raw bytes and never become key events.
    function automatic logic is_response(input logic [7:0] b);
        return (b == BAT) || (b == ACK) || (b == ECHO) ||
               (b == RESEND) || (b == ERR0) || (b == ERR1);
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Synchronises the PS/2 clock and data lines, debounces the clock and
// emits a registered one-cycle strobe on each filtered falling edge.
module ps2_edge_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_line_i,
    input  logic data_line_i,
    output logic data_o,
    output logic fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fall_q, fall_d;

    // Synchronisers reset to the idle-high line level so release never looks like an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= 4'd0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], clk_line_i};
            data_sync_q <= {data_sync_q[0], data_line_i};
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        fall_d = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign data_o = data_sync_q[1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver: deserialises 11-bit frames and folds set-2
// prefixes (E0, F0, E1 pause) into single key events.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 8000
) (
    input  logic       clk_sys_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       key_strobe_o,
    output logic [7:0] key_code_o,
    output logic       key_extended_o,
    output logic       key_pressed_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

    logic fall;
    logic sample;

    ps2_edge_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_i       (clk_sys_i),
        .rst_i       (reset_i),
        .clk_line_i  (ps2_clk_i),
        .data_line_i (ps2_data_i),
        .data_o      (sample),
        .fall_o      (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          ok_q, ok_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [2:0]    pause_q, pause_d;

    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          key_strobe_q, key_strobe_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d;
    logic          key_pressed_q, key_pressed_d;
    logic          frame_err_q, frame_err_d;

    logic          accept;
    logic          err;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            par_q         <= 1'b0;
            ok_q          <= 1'b0;
            to_cnt_q      <= '0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            pause_q       <= 3'd0;
            rx_byte_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            key_strobe_q  <= 1'b0;
            key_code_q    <= 8'd0;
            key_ext_q     <= 1'b0;
            key_pressed_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            ok_q          <= ok_d;
            to_cnt_q      <= to_cnt_d;
            ext_q         <= ext_d;
            rel_q         <= rel_d;
            pause_q       <= pause_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            key_strobe_q  <= key_strobe_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_pressed_q <= key_pressed_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Frame FSM: advances on filtered falls, or aborts on the mid-frame timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ok_d      = ok_q;
        to_cnt_d  = '0;
        accept    = 1'b0;
        err       = 1'b0;

        if (state_q != StIdle) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!sample) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {sample, shift_q[7:1]};
                    par_d     = par_q ^ sample;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    ok_d    = (sample == par_q);
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (sample && ok_q) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            endcase
        end else if ((state_q != StIdle) && (to_cnt_d == TimeoutCnt)) begin
            state_d  = StIdle;
            to_cnt_d = '0;
            err      = 1'b1;
        end
    end

    // Byte classification; outputs register one cycle after the stop-bit fall.
    always_comb begin
        ext_d         = ext_q;
        rel_d         = rel_q;
        pause_d       = pause_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = 1'b0;
        key_strobe_d  = 1'b0;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_pressed_d = key_pressed_q;
        frame_err_d   = 1'b0;

        if (err) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
            pause_d     = 3'd0;
        end

        if (accept) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            if (pause_q != 3'd0) begin
                pause_d = pause_q - 3'd1;
            end else if (shift_q == PFX_PAUSE) begin
                pause_d = PAUSE_TAIL;
            end else if (shift_q == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PFX_REL) begin
                rel_d = 1'b1;
            end else if (!is_response(shift_q)) begin
                key_strobe_d  = 1'b1;
                key_code_d    = shift_q;
                key_ext_d     = ext_q;
                key_pressed_d = ~rel_q;
                ext_d         = 1'b0;
                rel_d         = 1'b0;
            end
        end
    end

    assign rx_byte_o      = rx_byte_q;
    assign rx_valid_o     = rx_valid_q;
    assign key_strobe_o   = key_strobe_q;
    assign key_code_o     = key_code_q;
    assign key_extended_o = key_ext_q;
    assign key_pressed_o  = key_pressed_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: table of frames plus hand-written sequences
// for timeout, clock glitch and mid-frame reset.
module tb_ps2_key_rx;

    localparam int unsigned FL   = 4;
    localparam int unsigned TO   = 8000;
    localparam int unsigned HALF = 20;
    localparam int unsigned LAT  = 3 + FL;
    localparam int NV = 27;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_pressed;
    logic       frame_err;

    ps2_key_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk_sys_i      (clk),
        .reset_i        (reset),
        .ps2_clk_i      (ps2_clk),
        .ps2_data_i     (ps2_data),
        .rx_byte_o      (rx_byte),
        .rx_valid_o     (rx_valid),
        .key_strobe_o   (key_strobe),
        .key_code_o     (key_code),
        .key_extended_o (key_extended),
        .key_pressed_o  (key_pressed),
        .frame_err_o    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rx = 0, n_key = 0, n_err = 0;
    int rx_cyc = 0, key_cyc = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                n_rx   <= n_rx + 1;
                rx_cyc <= cyc;
            end
            if (key_strobe) begin
                n_key   <= n_key + 1;
                key_cyc <= cyc;
            end
            if (frame_err) begin
                n_err   <= n_err + 1;
                err_cyc <= cyc;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int fall_cyc = 0;
    int stop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        ps2_bit(1'b1);
        stop_cyc = fall_cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        int         rx;
        int         key;
        int         err;
        logic [7:0] code;
        logic       ext;
        logic       pr;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, key0, err0;
        logic [7:0] exp_byte;

        vecs[0]  = '{8'h1C, 1'b0, 1, 1, 0, 8'h1C, 1'b0, 1'b1};
        vecs[1]  = '{8'hE0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b1};
        vecs[2]  = '{8'hF0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b1};
        vecs[3]  = '{8'h75, 1'b0, 1, 1, 0, 8'h75, 1'b1, 1'b0};
        vecs[4]  = '{8'h1C, 1'b0, 1, 1, 0, 8'h1C, 1'b0, 1'b1};
        vecs[5]  = '{8'hE0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b1};
        vecs[6]  = '{8'h1C, 1'b1, 0, 0, 1, 8'h1C, 1'b0, 1'b1};
        vecs[7]  = '{8'hF0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b1};
        vecs[8]  = '{8'h1C, 1'b0, 1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[9]  = '{8'hE1, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[10] = '{8'h14, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[11] = '{8'h77, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{8'hE1, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[13] = '{8'hF0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[14] = '{8'h14, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[15] = '{8'hF0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[16] = '{8'h77, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[17] = '{8'h29, 1'b0, 1, 1, 0, 8'h29, 1'b0, 1'b1};
        vecs[18] = '{8'hFA, 1'b0, 1, 0, 0, 8'h29, 1'b0, 1'b1};
        vecs[19] = '{8'hE0, 1'b0, 1, 0, 0, 8'h29, 1'b0, 1'b1};
        vecs[20] = '{8'hE0, 1'b0, 1, 0, 0, 8'h29, 1'b0, 1'b1};
        vecs[21] = '{8'h6B, 1'b0, 1, 1, 0, 8'h6B, 1'b1, 1'b1};
        vecs[22] = '{8'hF0, 1'b0, 1, 0, 0, 8'h6B, 1'b1, 1'b1};
        vecs[23] = '{8'hF0, 1'b0, 1, 0, 0, 8'h6B, 1'b1, 1'b1};
        vecs[24] = '{8'hAA, 1'b0, 1, 0, 0, 8'h6B, 1'b1, 1'b1};
        vecs[25] = '{8'h12, 1'b0, 1, 1, 0, 8'h12, 1'b0, 1'b0};
        vecs[26] = '{8'h00, 1'b0, 1, 0, 0, 8'h12, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset rx_byte", 32'(rx_byte), 32'h0);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset key_strobe", 32'(key_strobe), 32'h0);
        check("reset key_code", 32'(key_code), 32'h0);
        check("reset key_extended", 32'(key_extended), 32'h0);
        check("reset key_pressed", 32'(key_pressed), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);

        exp_byte = 8'h00;
        for (int i = 0; i < NV; i++) begin
            rx0 = n_rx; key0 = n_key; err0 = n_err;
            send_frame(vecs[i].data, vecs[i].flip);
            if (vecs[i].rx != 0) exp_byte = vecs[i].data;
            check($sformatf("v%0d rx_count", i), 32'(n_rx - rx0), 32'(vecs[i].rx));
            check($sformatf("v%0d key_count", i), 32'(n_key - key0), 32'(vecs[i].key));
            check($sformatf("v%0d err_count", i), 32'(n_err - err0), 32'(vecs[i].err));
            check($sformatf("v%0d rx_byte", i), 32'(rx_byte), 32'(exp_byte));
            check($sformatf("v%0d key_code", i), 32'(key_code), 32'(vecs[i].code));
            check($sformatf("v%0d key_extended", i), 32'(key_extended), 32'(vecs[i].ext));
            check($sformatf("v%0d key_pressed", i), 32'(key_pressed), 32'(vecs[i].pr));
            if (i == 0) begin
                check("latency key_strobe", 32'(key_cyc - stop_cyc), 32'(LAT));
                check("latency rx_valid", 32'(rx_cyc - stop_cyc), 32'(LAT));
            end
        end

        // Timeout mid-frame after E0: one error, flags cleared.
        send_frame(8'hE0, 1'b0);
        rx0 = n_rx; err0 = n_err;
        send_partial(8'h5A, 4);
        repeat (TO + 10) @(negedge clk);
        check("timeout err_count", 32'(n_err - err0), 32'd1);
        check("timeout err_time", 32'(err_cyc - fall_cyc), 32'(LAT + TO));
        check("timeout rx_count", 32'(n_rx - rx0), 32'd0);
        key0 = n_key;
        send_frame(8'h5A, 1'b0);
        check("after timeout key_count", 32'(n_key - key0), 32'd1);
        check("after timeout key_code", 32'(key_code), 32'h5A);
        check("after timeout key_extended", 32'(key_extended), 32'h0);
        check("after timeout key_pressed", 32'(key_pressed), 32'h1);

        // Short clock glitch in idle must not produce a fall.
        rx0 = n_rx; err0 = n_err;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch err_count", 32'(n_err - err0), 32'd0);
        check("glitch rx_count", 32'(n_rx - rx0), 32'd0);
        key0 = n_key;
        send_frame(8'h1C, 1'b0);
        check("after glitch key_count", 32'(n_key - key0), 32'd1);
        check("after glitch err_count", 32'(n_err - err0), 32'd0);
        check("after glitch key_code", 32'(key_code), 32'h1C);

        // Reset mid-DATA after an E0 prefix.
        send_frame(8'hE0, 1'b0);
        rx0 = n_rx; err0 = n_err;
        send_partial(8'h05, 3);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid reset rx_byte", 32'(rx_byte), 32'h0);
        check("mid reset key_code", 32'(key_code), 32'h0);
        check("mid reset key_pressed", 32'(key_pressed), 32'h0);
        check("mid reset key_extended", 32'(key_extended), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mid reset rx_count", 32'(n_rx - rx0), 32'd0);
        key0 = n_key;
        send_frame(8'h5A, 1'b0);
        check("after reset rx_count", 32'(n_rx - rx0), 32'd1);
        check("after reset key_count", 32'(n_key - key0), 32'd1);
        check("after reset err_count", 32'(n_err - err0), 32'd0);
        check("after reset key_code", 32'(key_code), 32'h5A);
        check("after reset key_extended", 32'(key_extended), 32'h0);
        check("after reset key_pressed", 32'(key_pressed), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
